// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, instruction/ALU decoder, NZCV flag
// register and condition-code gating of every architectural write.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cond, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        cond_q, cond_ex;
    logic        ir_w, fetch, reg_w, mem_w, br, alu_op;
    logic        dp_nop, is_arith, pcs;
    logic [1:0]  alu_ctl, flag_w;
    logic        unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    // Main sequencer: next state plus raw (ungated) control strobes
    always_comb begin
        state_next = FETCH;
        ir_w       = 1'b0;
        fetch      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        br         = 1'b0;
        alu_op     = 1'b0;
        case (state)
            FETCH: begin
                state_next = DECODE;
                ir_w       = 1'b1;
                fetch      = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_next = funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                state_next = funct[0] ? MEMRD : MEMWR;
                ALUSrcB    = 2'b01;
            end
            MEMRD: begin
                state_next = MEMWB;
                AdrSrc     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECR: begin
                state_next = ALUWB;
                alu_op     = 1'b1;
            end
            EXECI: begin
                state_next = ALUWB;
                ALUSrcB    = 2'b01;
                alu_op     = 1'b1;
            end
            // An unsupported DP command is a NOP: it never writes Rd
            ALUWB: reg_w = ~dp_nop;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                br        = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        alu_ctl  = 2'b00;
        dp_nop   = 1'b0;
        is_arith = 1'b0;
        case (funct[4:1])
            4'b0100: is_arith = 1'b1;
            4'b0010: begin alu_ctl = 2'b01; is_arith = 1'b1; end
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            default: dp_nop = 1'b1;
        endcase
    end

    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign flag_w[1]  = alu_op & funct[0] & ~dp_nop;
    assign flag_w[0]  = alu_op & funct[0] & is_arith;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = Flags[2];
            4'h1: cond_ex = ~Flags[2];
            4'h2: cond_ex = Flags[1];
            4'h3: cond_ex = ~Flags[1];
            4'h4: cond_ex = Flags[3];
            4'h5: cond_ex = ~Flags[3];
            4'h6: cond_ex = Flags[0];
            4'h7: cond_ex = ~Flags[0];
            4'h8: cond_ex = Flags[1] & ~Flags[2];
            4'h9: cond_ex = ~Flags[1] | Flags[2];
            4'hA: cond_ex = (Flags[3] == Flags[0]);
            4'hB: cond_ex = (Flags[3] != Flags[0]);
            4'hC: cond_ex = ~Flags[2] & (Flags[3] == Flags[0]);
            4'hD: cond_ex = Flags[2] | (Flags[3] != Flags[0]);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Condition is frozen leaving DECODE so flag writes in EXEC cannot change it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FETCH;
            Flags  <= 4'h0;
            cond_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                cond_q <= cond_ex;
            if (cond_q && flag_w[1])
                Flags[3:2] <= ALUFlags[3:2];
            if (cond_q && flag_w[0])
                Flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs      = br | (reg_w & (rd == 4'hF));
    assign PCWrite  = reset & (fetch | (pcs & cond_q));
    assign RegWrite = reset & reg_w & cond_q;
    assign MemWrite = reset & mem_w & cond_q;
    assign IRWrite  = reset & ir_w;
    assign ImmSrc   = op;
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign State    = state;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle ARM datapath. It sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Decodes Instr[31:12] and holds the NZCV flags register. Gates all architectural writes with the condition-code check.
- Drives every select and enable input of the datapath, plus MemWrite to data/instruction memory.

Parameters:
- None.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- Instr  in  20  Instr[31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  out  1  PC register load enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register load enable.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- RegSrc  out  2  [0]: RA1=R15; [1]: RA2=Rd.
- ALUSrcA  out  2  00=A, 01=PC, 10=ALUOut.
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals op.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- Flags  out  4  architectural NZCV register (debug/verification).
- State  out  4  current FSM state encoding (debug/verification).

Behaviour:
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Codes 10–15 go to FETCH on the next edge.

Reset:
- When reset==0 at an edge: State<=FETCH, Flags<=0, cond_q<=0.
- While reset==0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.

Transitions:
- FETCH→DECODE.
- DECODE, by op:
  - op=00 & funct[5]=0 → EXECR.
  - op=00 & funct[5]=1 → EXECI.
  - op=01 → MEMADR.
  - op=10 → BRANCH.
  - op=11 → FETCH (NOP, no writes).
- MEMADR: funct[0]=1 → MEMRD, funct[0]=0 → MEMWR.
- MEMRD→MEMWB.
- EXECR/EXECI→ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH → FETCH.
- Instruction latencies in cycles: DP=4, LDR=5, STR=4, B=3, op11=2.

Per-state outputs (unlisted signals = 0; ALUControl=ADD unless stated):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional).
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=00, ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW.
- MEMWR: AdrSrc=1, MemW.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALU decoder active.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALU decoder active.
- ALUWB: ResultSrc=00, RegW.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Br.

Decoder (combinational, valid in all states):
- ImmSrc=op.
- RegSrc[0]=(op==10).
- RegSrc[1]=(op==01).

ALU decoder (cmd=funct[4:1], S=funct[0]):
- cmd 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
- Any other cmd → ADD, with RegW and FlagW suppressed (NOP).
- FlagW[1]=S.
- FlagW[0]=S & (ADD|SUB).

Condition logic:
- CondEx is evaluated from cond and the Flags register. Codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 → 0.
- cond_q<=CondEx at the edge leaving DECODE. All later states use cond_q.
- PCS = Br | (RegW & Rd==15).
- RegWrite = RegW & cond_q.
- MemWrite = MemW & cond_q.
- PCWrite = FETCH | (PCS & cond_q).
- Flags update at the edge leaving EXECR/EXECI, only if cond_q:
  - FlagW[1] → Flags[3:2]<=ALUFlags[3:2].
  - FlagW[0] → Flags[1:0]<=ALUFlags[1:0].
- Updated flags are first visible to the next instruction's DECODE.

Boundary cases:
- A failed condition still walks the full state path; only writes are suppressed.
- Reset mid-instruction aborts it and returns to FETCH with no write pulse.

Test Plan:
1. reset=0 for 3 cycles → State=0, Flags=0, all enables 0. Release → FETCH shows IRWrite=1, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
2. Instr=0xE0821003 (ADD R1,R2,R3) → States 0,1,6,8,0. EXECR ALUControl=00, ALUSrcB=00. ALUWB RegWrite=1, PCWrite=0.
3. 0xE5921004 (LDR) → 0,1,2,3,4: MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1. Then 0xE5821004 (STR) → 0,1,2,5: MemWrite=1 in MEMWR only.
4. 0xE2500001 (SUBS imm) with ALUFlags=0110 in EXECI → Flags=0110 after ALUWB. Then 0x0A000002 (BEQ) → BRANCH PCWrite=1. Repeat with Flags=0000 → PCWrite=0 in BRANCH.
5. Flags=0100, 0x10821003 (ADDNE) → ALUWB RegWrite=0. Then 0x1092F003 (ADDSNE, Rd=15) → PCWrite=0, RegWrite=0, Flags unchanged.
6. 0xE082F003 (Rd=15) → ALUWB RegWrite=1, PCWrite=1. 0xEC000000 (op=11) → 0,1,0 with no write enables. Force reset=0 during MEMWR → MemWrite=0, State=0 next cycle.
